sync_fifo_flags: RTL and testbench

//  Parametrised single-clock FIFO. Supports any depth (non-power-of-2 allowed).

---
 rtl/sync_fifo_pkg.sv | 24 ++
 rtl/sync_fifo_ram.sv | 48 ++++
 rtl/sync_fifo_flags.sv | 128 ++++++++++++
 tb/tb_sync_fifo_flags.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared types and helpers for the sync_fifo_flags FIFO.
// Pointer wrap is explicit, so any depth >= 2 works.
package sync_fifo_pkg;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_status_t;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_next(input int ptr, input int depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// 1W1R storage array with a registered read port.
// Only the read register is reset; the array itself is never cleared.
module sync_fifo_ram
    import sync_fifo_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_W     = ptr_w(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [DATA_WIDTH-1:0] rd_data_d;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read samples the pre-write word, so a same-edge write to rd_addr returns old data.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem[rd_addr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count and almost-full/empty flags.
// Define SYNC_FIFO_ERR_EN to enable sticky overflow/underflow flags.
module sync_fifo_flags
    import sync_fifo_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int AF_LEVEL   = 6,
    parameter int AE_LEVEL   = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              wr_en,
    input  logic [DATA_WIDTH-1:0]             wr_data,
    input  logic                              rd_en,
    output logic [DATA_WIDTH-1:0]             rd_data,
    output logic                              rd_valid,
    output logic                              full,
    output logic                              empty,
    output logic                              almost_full,
    output logic                              almost_empty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   count,
    output logic                              overflow,
    output logic                              underflow
);

    localparam int PTR_W = ptr_w(FIFO_DEPTH);
    localparam int CNT_W = cnt_w(FIFO_DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             rd_valid_q, rd_valid_d;
    logic             push, pop;
    fifo_status_t     status;

    always_comb begin
        status.full         = (count_q == CNT_W'(FIFO_DEPTH));
        status.empty        = (count_q == '0);
        status.almost_full  = (count_q >= CNT_W'(AF_LEVEL));
        status.almost_empty = (count_q <= CNT_W'(AE_LEVEL));
    end

    // A pop frees a slot in the same edge, so a full FIFO still takes a push.
    assign push = wr_en & (~status.full | rd_en);
    assign pop  = rd_en & ~status.empty;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rd_valid_d = pop;
        if (push) begin
            wr_ptr_d = PTR_W'(ptr_next(int'(wr_ptr_q), FIFO_DEPTH));
        end
        if (pop) begin
            rd_ptr_d = PTR_W'(ptr_next(int'(rd_ptr_q), FIFO_DEPTH));
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    sync_fifo_ram #(
        .DEPTH      (FIFO_DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_W     (PTR_W)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_addr (wr_ptr_q),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_addr (rd_ptr_q),
        .rd_data (rd_data)
    );

`ifdef SYNC_FIFO_ERR_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    always_comb begin
        overflow_d  = overflow_q | (wr_en & status.full & ~rd_en);
        underflow_d = underflow_q | (rd_en & status.empty);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

    assign rd_valid     = rd_valid_q;
    assign full         = status.full;
    assign empty        = status.empty;
    assign almost_full  = status.almost_full;
    assign almost_empty = status.almost_empty;
    assign count        = count_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags: depth-8 and depth-5 instances share stimulus,
// each checked every cycle against a list-based model.
module tb_sync_fifo_flags;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic [7:0] wr_data = 8'h00;

    logic [7:0] rd_data_a, rd_data_b;
    logic       rd_valid_a, rd_valid_b;
    logic       full_a, full_b, empty_a, empty_b;
    logic       af_a, af_b, ae_a, ae_b;
    logic [3:0] count_a;
    logic [2:0] count_b;
    logic       ovf_a, ovf_b, unf_a, unf_b;

    int checks = 0;
    int errors = 0;

`ifdef SYNC_FIFO_ERR_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif

    localparam int DEP [2] = '{8, 5};
    localparam int AFL [2] = '{6, 4};
    localparam int AEL [2] = '{2, 1};

    always #5 clk = ~clk;

    sync_fifo_flags #(
        .FIFO_DEPTH(8), .DATA_WIDTH(8), .AF_LEVEL(6), .AE_LEVEL(2)
    ) dut_a (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(rd_data_a), .rd_valid(rd_valid_a),
        .full(full_a), .empty(empty_a), .almost_full(af_a),
        .almost_empty(ae_a), .count(count_a),
        .overflow(ovf_a), .underflow(unf_a)
    );

    sync_fifo_flags #(
        .FIFO_DEPTH(5), .DATA_WIDTH(8), .AF_LEVEL(4), .AE_LEVEL(1)
    ) dut_b (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(rd_data_b), .rd_valid(rd_valid_b),
        .full(full_b), .empty(empty_b), .almost_full(af_b),
        .almost_empty(ae_b), .count(count_b),
        .overflow(ovf_b), .underflow(unf_b)
    );

    // Model: element 0 of each list is the oldest word.
    logic [7:0] m_list [2][8];
    int         m_cnt [2];
    logic [7:0] m_rd [2];
    logic       m_rv [2];
    logic       m_ov [2];
    logic       m_un [2];
    bit         mf, me, mpu, mpo;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                m_cnt[k] = 0;
                m_rd[k]  = 8'h00;
                m_rv[k]  = 1'b0;
                m_ov[k]  = 1'b0;
                m_un[k]  = 1'b0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                mf  = (m_cnt[k] == DEP[k]);
                me  = (m_cnt[k] == 0);
                mpu = wr_en && (!mf || rd_en);
                mpo = rd_en && !me;
                if (wr_en && mf && !rd_en) m_ov[k] = 1'b1;
                if (rd_en && me) m_un[k] = 1'b1;
                m_rv[k] = mpo;
                if (mpo) begin
                    m_rd[k] = m_list[k][0];
                    for (int j = 0; j < 7; j++) m_list[k][j] = m_list[k][j+1];
                    m_cnt[k] = m_cnt[k] - 1;
                end
                if (mpu) begin
                    m_list[k][m_cnt[k]] = wr_data;
                    m_cnt[k] = m_cnt[k] + 1;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("a_count", 32'(count_a), m_cnt[0]);
        chk("a_full", 32'(full_a), 32'(m_cnt[0] == DEP[0]));
        chk("a_empty", 32'(empty_a), 32'(m_cnt[0] == 0));
        chk("a_af", 32'(af_a), 32'(m_cnt[0] >= AFL[0]));
        chk("a_ae", 32'(ae_a), 32'(m_cnt[0] <= AEL[0]));
        chk("a_rv", 32'(rd_valid_a), 32'(m_rv[0]));
        chk("a_rd", 32'(rd_data_a), 32'(m_rd[0]));
        chk("a_ovf", 32'(ovf_a), 32'(ERR_ON & m_ov[0]));
        chk("a_unf", 32'(unf_a), 32'(ERR_ON & m_un[0]));
        chk("b_count", 32'(count_b), m_cnt[1]);
        chk("b_full", 32'(full_b), 32'(m_cnt[1] == DEP[1]));
        chk("b_empty", 32'(empty_b), 32'(m_cnt[1] == 0));
        chk("b_af", 32'(af_b), 32'(m_cnt[1] >= AFL[1]));
        chk("b_ae", 32'(ae_b), 32'(m_cnt[1] <= AEL[1]));
        chk("b_rv", 32'(rd_valid_b), 32'(m_rv[1]));
        chk("b_rd", 32'(rd_data_b), 32'(m_rd[1]));
        chk("b_ovf", 32'(ovf_b), 32'(ERR_ON & m_ov[1]));
        chk("b_unf", 32'(unf_b), 32'(ERR_ON & m_un[1]));
    end

    task automatic step(input logic we, input logic [7:0] wd,
                        input logic re);
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    initial begin
        int d;
        #12;
        chk("rst_count", 32'(count_a), 0);
        chk("rst_empty", 32'(empty_a), 1);
        chk("rst_full", 32'(full_a), 0);
        chk("rst_ae", 32'(ae_a), 1);
        chk("rst_af", 32'(af_a), 0);
        chk("rst_rv", 32'(rd_valid_a), 0);
        chk("rst_rd", 32'(rd_data_a), 0);
        @(negedge clk);
        rst = 1'b0;

        // fill 1..8, then drain in order
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 8'(i), 1'b0);
            chk("t1_count", 32'(count_a), i);
            chk("t1_ae", 32'(ae_a), 32'(i <= 2));
            chk("t1_af", 32'(af_a), 32'(i >= 6));
            chk("t1_full", 32'(full_a), 32'(i == 8));
        end
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 8'h00, 1'b1);
            chk("t1_rv", 32'(rd_valid_a), 1);
            chk("t1_rd", 32'(rd_data_a), i);
        end
        chk("t1_empty", 32'(empty_a), 1);
        step(1'b0, 8'h00, 1'b0);
        chk("t1_rv_idle", 32'(rd_valid_a), 0);
        chk("t1_rd_hold", 32'(rd_data_a), 8);

        // full: rejected push, then push+pop
        for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h10 + i), 1'b0);
        step(1'b1, 8'hAA, 1'b0);
        chk("t2_count", 32'(count_a), 8);
        chk("t2_ovf", 32'(ovf_a), 32'(ERR_ON));
        step(1'b1, 8'h55, 1'b1);
        chk("t3_rd", 32'(rd_data_a), 32'h10);
        chk("t3_count", 32'(count_a), 8);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 8'h00, 1'b1);
            chk("t3_drain", 32'(rd_data_a), (i < 7) ? 32'h11 + i : 32'h55);
        end

        // empty: push+pop, pop is rejected
        step(1'b1, 8'h77, 1'b1);
        chk("t4_rv", 32'(rd_valid_a), 0);
        chk("t4_count", 32'(count_a), 1);
        step(1'b0, 8'h00, 1'b1);
        chk("t4_rd", 32'(rd_data_a), 32'h77);
        chk("t4_rv2", 32'(rd_valid_a), 1);

        // steady push+pop at count 3 across pointer wrap
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h70 + i), 1'b0);
        for (int i = 0; i < 20; i++) begin
            d = (8'h73 + i) & 8'h7f;
            step(1'b1, 8'(d), 1'b1);
            chk("t5_rd_a", 32'(rd_data_a), (8'h70 + i) & 8'h7f);
            chk("t5_rd_b", 32'(rd_data_b), (8'h70 + i) & 8'h7f);
            chk("t5_cnt_b", 32'(count_b), 3);
        end
        for (int i = 20; i < 23; i++) begin
            step(1'b0, 8'h00, 1'b1);
            chk("t5_tail", 32'(rd_data_a), (8'h70 + i) & 8'h7f);
        end

        // async reset mid-stream
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hC0 + i), 1'b0);
        step(1'b0, 8'h00, 1'b1);
        chk("t6_pre", 32'(count_a), 4);
        #1 rst = 1'b1;
        #1;
        chk("t6_count", 32'(count_a), 0);
        chk("t6_empty", 32'(empty_a), 1);
        chk("t6_rv", 32'(rd_valid_a), 0);
        chk("t6_ovf", 32'(ovf_a), 0);
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 8'h00, 1'b1);
        chk("t6_unf", 32'(unf_a), 32'(ERR_ON));
        chk("t6_count2", 32'(count_a), 0);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
